// File: rtl/motoro3_pkg.sv
// Shared step encodings, phase table and period limits for the motoro3
// six-step commutation controller.
package motoro3_pkg;

  typedef enum logic [3:0] {
    STEP_IDLE = 4'd0,
    STEP_1    = 4'd1,
    STEP_2    = 4'd2,
    STEP_3    = 4'd3,
    STEP_4    = 4'd4,
    STEP_5    = 4'd5,
    STEP_6    = 4'd6,
    STEP_STOP = 4'd7
  } step_e;

  // Shortest legal step period; anything smaller is raised to this on load.
  localparam int unsigned PERIOD_MIN = 2;

  typedef struct packed {
    logic [2:0] en;  // {a,b,c} enables
    logic [2:0] hi;  // {a,b,c} high(1)/low(0) selects
  } phase_t;

  function automatic phase_t phase_of(input step_e s);
    phase_t p;
    p = '0;
    case (s)
      STEP_1:  p = '{en: 3'b101, hi: 3'b100};
      STEP_2:  p = '{en: 3'b011, hi: 3'b010};
      STEP_3:  p = '{en: 3'b110, hi: 3'b010};
      STEP_4:  p = '{en: 3'b101, hi: 3'b001};
      STEP_5:  p = '{en: 3'b011, hi: 3'b001};
      STEP_6:  p = '{en: 3'b110, hi: 3'b100};
      default: p = '0;
    endcase
    return p;
  endfunction

  function automatic step_e step_next(input step_e s, input logic fwd);
    step_e n;
    n = s;
    case (s)
      STEP_1:  n = fwd ? STEP_2 : STEP_6;
      STEP_2:  n = fwd ? STEP_3 : STEP_1;
      STEP_3:  n = fwd ? STEP_4 : STEP_2;
      STEP_4:  n = fwd ? STEP_5 : STEP_3;
      STEP_5:  n = fwd ? STEP_6 : STEP_4;
      STEP_6:  n = fwd ? STEP_1 : STEP_5;
      default: n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/motoro3_period_ramp.sv
// Active step period register with linear soft-start ramp toward a target,
// loaded on a start and stepped once per completed electrical round.
module motoro3_period_ramp
  import motoro3_pkg::*;
#(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             round_i,
  input  logic [CNT_W-1:0] target_i,
  input  logic [CNT_W-1:0] ramp_dec_i,
  output logic [CNT_W-1:0] cur_period_o,
  output logic [CNT_W-1:0] nxt_period_o
);

  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(PERIOD_MIN);

  logic [CNT_W-1:0] per_q, per_d;

  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] v);
    return (v < MIN_P) ? MIN_P : v;
  endfunction

  // Move one ramp step toward tgt without overshooting; the extra bit
  // catches both borrow and carry so the result never wraps.
  function automatic logic [CNT_W-1:0] ramp_toward(input logic [CNT_W-1:0] cur,
                                                   input logic [CNT_W-1:0] tgt,
                                                   input logic [CNT_W-1:0] dec);
    logic [CNT_W:0] sum;
    logic [CNT_W:0] dif;
    logic [CNT_W-1:0] res;
    sum = {1'b0, cur} + {1'b0, dec};
    dif = {1'b0, cur} - {1'b0, dec};
    res = cur;
    if (cur > tgt) begin
      res = (dif[CNT_W] || (dif[CNT_W-1:0] < tgt)) ? tgt : dif[CNT_W-1:0];
    end else if (cur < tgt) begin
      res = (sum > {1'b0, tgt}) ? tgt : sum[CNT_W-1:0];
    end
    return res;
  endfunction

  always_comb begin
    per_d = per_q;
    if (load_i) begin
      per_d = clamp_period(load_val_i);
    end else if (round_i) begin
      per_d = clamp_period(ramp_toward(per_q, target_i, ramp_dec_i));
    end
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      per_q <= '0;
    end else begin
      per_q <= per_d;
    end
  end

  assign cur_period_o = per_q;
  assign nxt_period_o = per_d;

endmodule

// File: rtl/motoro3_commutation_ctrl.sv
// Six-step BLDC commutation controller: step sequencing with direction,
// dead-time blanking, latched force stop, soft-start ramp and round counting.
module motoro3_commutation_ctrl
  import motoro3_pkg::*;
#(
  parameter int CNT_W    = 25,
  parameter int ROUND_W  = 32,
  parameter int DEAD_CYC = 10
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic               start,
  input  logic               dir,
  input  logic               stop_req,
  input  logic [CNT_W-1:0]   period_start,
  input  logic [CNT_W-1:0]   period_target,
  input  logic [CNT_W-1:0]   ramp_dec,
  output logic               aE,
  output logic               bE,
  output logic               cE,
  output logic               aH1_L0,
  output logic               bH1_L0,
  output logic               cH1_L0,
  output logic [3:0]         step,
  output logic [CNT_W-1:0]   cnt,
  output logic [CNT_W-1:0]   cur_period,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               at_speed,
  output logic               dead
);

  localparam logic [CNT_W:0] DEAD_V = (CNT_W+1)'(DEAD_CYC);

  step_e              step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic               start_q;

  logic               start_edge;
  logic               running;
  logic               expire;
  logic               load;
  logic               round_done;
  logic               dead_w;
  logic [CNT_W-1:0]   per_cur;
  logic [CNT_W-1:0]   per_nxt;
  logic [CNT_W-1:0]   elapsed;
  phase_t             ph;

  function automatic logic [ROUND_W-1:0] sat_inc(input logic [ROUND_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_edge = start & ~start_q;
  assign running    = (step_q >= STEP_1) && (step_q <= STEP_6);
  assign expire     = (cnt_q <= CNT_W'(1));
  assign load       = start_edge && (step_q == STEP_IDLE);
  // A round ends on the last step of the direction sampled at expiry.
  assign round_done = running && !stop_req && start && expire &&
                      (dir ? (step_q == STEP_6) : (step_q == STEP_1));

  motoro3_period_ramp #(
    .CNT_W (CNT_W)
  ) u_ramp (
    .clk          (clk),
    .nRst         (nRst),
    .load_i       (load),
    .load_val_i   (period_start),
    .round_i      (round_done),
    .target_i     (period_target),
    .ramp_dec_i   (ramp_dec),
    .cur_period_o (per_cur),
    .nxt_period_o (per_nxt)
  );

  always_comb begin
    step_d  = step_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    case (step_q)
      STEP_IDLE: begin
        if (start_edge) begin
          step_d  = dir ? STEP_1 : STEP_6;
          cnt_d   = per_nxt;
          round_d = '0;
        end
      end
      STEP_STOP: begin
        if (!start) begin
          step_d = STEP_IDLE;
          cnt_d  = '0;
        end
      end
      STEP_1, STEP_2, STEP_3, STEP_4, STEP_5, STEP_6: begin
        // Force stop outranks a run drop and a coincident expiry.
        if (stop_req) begin
          step_d = STEP_STOP;
        end else if (!start) begin
          step_d = STEP_IDLE;
          cnt_d  = '0;
        end else if (expire) begin
          step_d = step_next(step_q, dir);
          cnt_d  = per_nxt;
          if (round_done) begin
            round_d = sat_inc(round_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        step_d = STEP_IDLE;
        cnt_d  = '0;
      end
    endcase
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      step_q  <= STEP_IDLE;
      cnt_q   <= '0;
      round_q <= '0;
      start_q <= 1'b0;
    end else begin
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      start_q <= start;
    end
  end

  // cnt is reloaded from cur_period at every step entry, so elapsed never wraps.
  assign elapsed = per_cur - cnt_q;
  assign dead_w  = running && ({1'b0, elapsed} < DEAD_V);
  assign ph      = (running && !dead_w) ? phase_of(step_q) : '0;

  assign {aE, bE, cE}             = ph.en;
  assign {aH1_L0, bH1_L0, cH1_L0} = ph.hi;
  assign step       = step_q;
  assign cnt        = cnt_q;
  assign cur_period = per_cur;
  assign round_cnt  = round_q;
  assign at_speed   = running && (per_cur == period_target);
  assign dead       = dead_w;

endmodule

// File: tb/tb_motoro3_commutation_ctrl.sv
// Bench for motoro3_commutation_ctrl: directed scenarios plus random stimulus
// against a cycle-level behavioural model of the commutation rules.
module tb_motoro3_commutation_ctrl;

  localparam int CNT_W    = 12;
  localparam int ROUND_W  = 2;
  localparam int DEAD_CYC = 1;
  localparam int RMAX     = (1 << ROUND_W) - 1;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic start = 1'b0;
  logic dir = 1'b1;
  logic stop_req = 1'b0;
  logic [CNT_W-1:0] period_start = 12'd4;
  logic [CNT_W-1:0] period_target = 12'd4;
  logic [CNT_W-1:0] ramp_dec = 12'd1;

  logic aE, bE, cE, aH1_L0, bH1_L0, cH1_L0;
  logic [3:0] step;
  logic [CNT_W-1:0] cnt, cur_period;
  logic [ROUND_W-1:0] round_cnt;
  logic at_speed, dead;

  motoro3_commutation_ctrl #(
    .CNT_W (CNT_W), .ROUND_W (ROUND_W), .DEAD_CYC (DEAD_CYC)
  ) dut (
    .clk (clk), .nRst (nRst), .start (start), .dir (dir), .stop_req (stop_req),
    .period_start (period_start), .period_target (period_target), .ramp_dec (ramp_dec),
    .aE (aE), .bE (bE), .cE (cE),
    .aH1_L0 (aH1_L0), .bH1_L0 (bH1_L0), .cH1_L0 (cH1_L0),
    .step (step), .cnt (cnt), .cur_period (cur_period), .round_cnt (round_cnt),
    .at_speed (at_speed), .dead (dead)
  );

  always #50 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  // Reference state: step number, remaining cycles, period, rounds, last start.
  int m_step, m_cnt, m_per, m_rnd;
  bit m_sp;
  int en_tbl[7] = '{0, 5, 3, 6, 5, 3, 6};
  int hi_tbl[7] = '{0, 4, 2, 2, 1, 1, 4};

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    m_step = 0; m_cnt = 0; m_per = 0; m_rnd = 0; m_sp = 1'b0;
  endtask

  task automatic model_tick();
    bit edge_s;
    bit rnd;
    int tgt, dec;
    edge_s = start && !m_sp;
    m_sp = start;
    tgt = int'(period_target);
    dec = int'(ramp_dec);
    if (m_step == 0) begin
      if (edge_s) begin
        m_step = dir ? 1 : 6;
        m_per = clampp(int'(period_start));
        m_cnt = m_per;
        m_rnd = 0;
      end
    end else if (m_step == 7) begin
      if (!start) begin m_step = 0; m_cnt = 0; end
    end else if (stop_req) begin
      m_step = 7;
    end else if (!start) begin
      m_step = 0; m_cnt = 0;
    end else if (m_cnt > 1) begin
      m_cnt = m_cnt - 1;
    end else begin
      rnd = dir ? (m_step == 6) : (m_step == 1);
      m_step = dir ? (m_step % 6) + 1 : ((m_step + 4) % 6) + 1;
      if (rnd) begin
        m_rnd = (m_rnd < RMAX) ? m_rnd + 1 : RMAX;
        if (m_per > tgt) m_per = (m_per - dec > tgt) ? m_per - dec : tgt;
        else if (m_per < tgt) m_per = (m_per + dec < tgt) ? m_per + dec : tgt;
        m_per = clampp(m_per);
      end
      m_cnt = m_per;
    end
  endtask

  task automatic check_all();
    bit run, ex_dead;
    int ex_en, ex_hi;
    run = (m_step >= 1) && (m_step <= 6);
    ex_dead = run && ((m_per - m_cnt) < DEAD_CYC);
    ex_en = (run && !ex_dead) ? en_tbl[m_step] : 0;
    ex_hi = (run && !ex_dead) ? hi_tbl[m_step] : 0;
    chk("step", int'(step), m_step);
    chk("cnt", int'(cnt), m_cnt);
    chk("cur_period", int'(cur_period), m_per);
    chk("round_cnt", int'(round_cnt), m_rnd);
    chk("enables", int'({aE, bE, cE}), ex_en);
    chk("hi_sel", int'({aH1_L0, bH1_L0, cH1_L0}), ex_hi);
    chk("at_speed", int'(at_speed), int'(run && (m_per == int'(period_target))));
    chk("dead", int'(dead), int'(ex_dead));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (nRst) model_tick(); else model_reset();
      @(posedge clk);
      check_all();
    end
  endtask

  // Advance until the model reaches step s; a missed bound is a failure.
  task automatic wait_step(input string tag, input int s, input int limit);
    int k;
    k = 0;
    while (m_step != s && k < limit) begin tick(1); k++; end
    chk(tag, int'(m_step == s), 1);
  endtask

  int exp_per[4] = '{16, 12, 10, 10};

  initial begin
    int prev, k, r;
    model_reset();
    // Reset and idle with stop_req toggling
    tick(3);
    nRst = 1'b1;
    for (int i = 0; i < 4; i++) begin stop_req = ~stop_req; tick(1); end
    stop_req = 1'b0;
    chk("idle_step", int'(step), 0);

    // Forward run, period 4, one dead cycle per step
    period_start = 12'd4; period_target = 12'd4; ramp_dec = 12'd1; dir = 1'b1;
    start = 1'b1;
    tick(1);
    chk("fwd_first_dead", int'({aE, bE, cE}), 0);
    tick(1);
    chk("fwd_step1_en", int'({aE, bE, cE}), 5);
    tick(23);
    chk("fwd_round1", int'(round_cnt), 1);
    chk("fwd_wrap", int'(step), 1);

    // Reverse run with a direction flip inside step 3
    start = 1'b0; tick(1);
    dir = 1'b0; start = 1'b1; tick(1);
    chk("rev_first", int'(step), 6);
    wait_step("rev_reach3", 3, 40);
    tick(1);
    dir = 1'b1;
    k = 0;
    while (m_step == 3 && k < 10) begin tick(1); k++; end
    chk("dirflip", int'(step), 4);

    // Soft-start ramp 20 -> 10 by 4
    start = 1'b0; tick(1);
    period_start = 12'd20; period_target = 12'd10; ramp_dec = 12'd4; dir = 1'b1;
    start = 1'b1; tick(1);
    chk("ramp_p0", int'(cur_period), 20);
    chk("ramp_as0", int'(at_speed), 0);
    for (r = 0; r < 4; r++) begin
      k = 0; prev = m_step;
      while (!(prev == 6 && m_step == 1) && k < 200) begin prev = m_step; tick(1); k++; end
      chk("ramp_per", int'(cur_period), exp_per[r]);
      chk("ramp_as", int'(at_speed), int'(exp_per[r] == 10));
    end

    // Force stop latched until start drops
    wait_step("stop_reach3", 3, 80);
    stop_req = 1'b1; tick(1);
    chk("stop_step", int'(step), 7);
    chk("stop_en", int'({aE, bE, cE}), 0);
    stop_req = 1'b0; tick(3);
    chk("stop_hold", int'(step), 7);
    start = 1'b0; tick(1);
    chk("stop_exit", int'(step), 0);
    start = 1'b1; tick(1);
    chk("restart_step", int'(step), 1);
    chk("restart_rnd", int'(round_cnt), 0);

    // Saturation of round_cnt and clamp of a zero period
    start = 1'b0; tick(1);
    period_start = 12'd0; period_target = 12'd2; ramp_dec = 12'd1;
    start = 1'b1; tick(1);
    chk("clamp_per", int'(cur_period), 2);
    tick(70);
    chk("round_sat", int'(round_cnt), 3);

    // Asynchronous reset in the middle of step 5
    wait_step("rst_reach5", 5, 20);
    #20 nRst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_step", int'(step), 0);
    @(posedge clk);
    tick(2);
    nRst = 1'b1;

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      if (!nRst) nRst = 1'b1;
      else if ($urandom_range(999) < 3) nRst = 1'b0;
      if ($urandom_range(99) < 2) start = ~start;
      stop_req = ($urandom_range(199) < 3);
      if ($urandom_range(99) < 4) dir = ~dir;
      if ($urandom_range(99) < 5) period_start = CNT_W'($urandom_range(12));
      if ($urandom_range(99) < 3) period_target = CNT_W'($urandom_range(14));
      if ($urandom_range(99) < 3) ramp_dec = CNT_W'($urandom_range(6));
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/motoro3_commutation_ctrl.md
Name: motoro3_commutation_ctrl

Overview:
Parametrised six-step BLDC commutation controller, the successor to the fixed-period motoro3 step machine. It drives the per-phase enable and high/low selects for phases a/b/c, and adds several features:
- runtime step period with a linear soft-start ramp toward a target period
- forward/reverse direction
- per-step dead-time blanking
- a latched force-stop state
- a saturating round counter
It sits between the host control registers and the gate-driver/PWM stage.

Parameters:
CNT_W, 25, width of step counter and all period values
ROUND_W, 32, width of round counter
DEAD_CYC, 10, clk cycles with all enables forced 0 at the start of every step (0 = none)

Ports:
clk  in  1  system clock (10 MHz); all registers update on falling edge
nRst  in  1  reset, asynchronous, active-low
start  in  1  level run request; rising edge starts motor
dir  in  1  1 = forward (1→6), 0 = reverse (6→1)
stop_req  in  1  force stop request (enter step 7)
period_start  in  CNT_W  initial step period, cycles, loaded on start edge
period_target  in  CNT_W  final step period, cycles
ramp_dec  in  CNT_W  period change applied per completed round
aE,bE,cE  out  1  phase enables
aH1_L0,bH1_L0,cH1_L0  out  1  phase high(1)/low(0) select
step  out  4  0 idle, 1..6 run, 7 force stop
cnt  out  CNT_W  remaining cycles in current step
cur_period  out  CNT_W  active step period
round_cnt  out  ROUND_W  completed electrical rounds
at_speed  out  1  cur_period == period_target while running
dead  out  1  high during dead-time blanking

Behaviour:
- Reset: step=0, cnt=0, cur_period=0, round_cnt=0, all enables/selects 0, at_speed=0, dead=0, start edge detector cleared.
- Phase table, as {aE,bE,cE}/{aH,bH,cH}:
  - step1 101/100, step2 011/010, step3 110/010
  - step4 101/001, step5 011/001, step6 110/100
  - step 0, step 7, and dead=1 all force 000/000.
- Clamp rule: any period value < 2 is clamped to 2 when loaded.
- Start edge: start rising (registered edge detect) while step is 0:
  - step ← dir ? 1 : 6
  - cur_period ← period_start
  - cnt ← period_start
  - round_cnt ← 0
  - A start edge while step is 1..7 is ignored.
- Run counter: cnt decrements by 1 per cycle. Expiry occurs when cnt ≤ 1, so each step lasts exactly cur_period cycles.
- Expiry: the next step is chosen using dir sampled at that cycle:
  - forward wraps 6→1, reverse wraps 1→6
  - cnt ← new cur_period
  - a dir change therefore takes effect only at a step boundary.
- Round: completes on expiry of step 6 (forward) or step 1 (reverse).
  - round_cnt increments and saturates at all-ones.
  - Same cycle, ramp: if cur_period > target, cur_period ← max(target, cur_period − ramp_dec); if cur_period < target, cur_period ← min(target, cur_period + ramp_dec).
  - Ramp arithmetic is done at CNT_W+1 bits, with no wrap.
- Dead-time: dead=1 for the first DEAD_CYC cycles of every step, i.e. while cur_period − cnt < DEAD_CYC. If DEAD_CYC ≥ cur_period, the step is fully blanked.
- Force stop: stop_req=1 while step is 1..6:
  - next cycle step ← 7, outputs all 0, cnt and round_cnt hold.
  - Step 7 is exited only when start=0, to step 0.
  - stop_req has priority over a simultaneous expiry.
- start=0 while step is 1..6: next cycle step ← 0, cnt ← 0, round_cnt holds. round_cnt is cleared only by the next start edge.
- period_target and ramp_dec may change at any time; they take effect at the next round boundary.
- at_speed=0 when step is 0 or 7.
- Reset asserted mid-run returns everything to reset values immediately.

Decomposition:
- Shared package motoro3_pkg holds:
  - step encodings: STEP_IDLE=0, STEP_STOP=7
  - the six-entry phase table as a constant function step→{E[2:0],H[2:0]}
  - the period clamp minimum (2)
- One sub-module is natural: motoro3_period_ramp, holding the cur_period register and the saturating ramp arithmetic, stepped by a round strobe.

Test Plan:
- Reset → after nRst release: all outputs 0, step 0, round_cnt 0; stop_req toggling while idle → step stays 0.
- Forward run (DEAD_CYC=1, period_start=target=4, dir=1), start pulse → step sequence 1,2,3,4,5,6,1, each held 4 cycles.
  - First cycle of each step has all enables 0.
  - round_cnt=1 after the 24th cycle; at_speed=1 throughout.
- Reverse run (dir=0, same periods) → sequence 6,5,4,3,2,1,6.
  - Flip dir mid-step 3 → next step is 4, not 2.
- Ramp (period_start=20, target=10, ramp_dec=4) → cur_period 20,16,12,10,10 at successive rounds; at_speed rises at 10.
- Force stop: stop_req at step 3 → next cycle step 7, enables 000, cnt frozen.
  - Release stop_req with start=1 → stays 7; drop start → step 0.
  - New start edge → step 1, round_cnt 0.
- Edges (ROUND_W=2): run 5 rounds → round_cnt saturates at 3. period_start=0 → clamped, steps last 2 cycles. nRst pulse mid-step 5 → immediate reset values.
